// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register responder.
// Optional feature macro: SPI_REG_AUTOINC_EN (address auto-increment between burst bytes).
package spi_reg_pkg;

    localparam int NUM_REGS     = 16;
    localparam int ADDR_W       = 4;
    localparam int CMD_READ_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Address used for the next byte of a burst.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return a + ADDR_W'(1);
`else
        return a;
`endif
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus edge detection in the clk domain.
module spi_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic cs_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_n_s,
    output logic cs_fall,
    output logic cs_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);

    // Bits [1:0] are the synchronizer, bit [2] holds the previous synced value.
    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cs_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], cs_n_i};
            sclk_q <= {sclk_q[1:0], sclk_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign cs_n_s    = cs_q[1];
    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] & cs_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave exposing 16 byte registers; command byte bit7 selects read/write.
// Define SPI_REG_AUTOINC_EN to auto-increment the address between burst bytes.
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              SPI_CS,
    input  logic              SPI_Clk,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    logic cs_n_s, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

    spi_sync_edge u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .cs_n_i    (SPI_CS),
        .sclk_i    (SPI_Clk),
        .mosi_i    (SPI_MOSI),
        .cs_n_s    (cs_n_s),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s)
    );

    state_e            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_mode_q, rd_mode_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wd_q, wd_d;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    logic [7:0]        regs_q [NUM_REGS];

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] na;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rd_mode_d = rd_mode_q;
        strobe_d  = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        settle_d  = settle_q;
        armed_d   = armed_q;
        rx_byte   = {rx_q[6:0], mosi_s};
        na        = next_addr(addr_q);

        // Synced CS reads as idle-high for two clks after reset; a CS already low
        // then must not look like a fresh fall, so accept falls only once armed.
        if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
        if (settle_q == 2'd3 && cs_n_s) armed_d = 1'b1;

        if (cs_rise) begin
            state_d  = IDLE;
            bitcnt_d = 3'd0;
            rx_d     = 8'h00;
            tx_d     = 8'h00;
        end else if (state_q == IDLE) begin
            if (cs_fall && armed_q) begin
                state_d  = CMD;
                bitcnt_d = 3'd0;
                rx_d     = 8'h00;
                tx_d     = STATUS_BYTE;
            end
        end else if (sclk_rise && !cs_n_s) begin
            rx_d     = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                if (state_q == CMD) begin
                    state_d   = DATA;
                    rd_mode_d = rx_byte[CMD_READ_BIT];
                    addr_d    = rx_byte[ADDR_W-1:0];
                    tx_d      = rx_byte[CMD_READ_BIT] ? regs_q[rx_byte[ADDR_W-1:0]] : STATUS_BYTE;
                end else begin
                    addr_d = na;
                    if (rd_mode_q) begin
                        tx_d = regs_q[na];
                    end else begin
                        tx_d     = STATUS_BYTE;
                        strobe_d = 1'b1;
                        wa_d     = addr_q;
                        wd_d     = rx_byte;
                    end
                end
            end
        end else if (sclk_fall && !cs_n_s && bitcnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bitcnt_q  <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            rd_mode_q <= 1'b0;
            strobe_q  <= 1'b0;
            wa_q      <= '0;
            wd_q      <= 8'h00;
            settle_q  <= 2'd0;
            armed_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rd_mode_q <= rd_mode_d;
            strobe_q  <= strobe_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            if (strobe_d) regs_q[wa_d] <= wd_d;
        end
    end

    assign SPI_MISO  = (state_q != IDLE) & tx_q[7];
    assign rd_data   = regs_q[rd_addr];
    assign wr_strobe = strobe_q;
    assign wr_addr   = wa_q;
    assign wr_data   = wd_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder with a register model and write/MISO scoreboards.
module tb_spi_reg_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       resetn;
    logic       SPI_CS;
    logic       SPI_Clk;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    spi_reg_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .SPI_CS    (SPI_CS),
        .SPI_Clk   (SPI_Clk),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [7:0]  model [16];
    logic [11:0] exp_wr_q [$];
    logic [7:0]  exp_miso_q [$];
    logic [11:0] obs_mem [256];
    int          obs_wr = 0;
    int          obs_rd = 0;

    // Every clk that wr_strobe is high is logged as one observed write.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1 && obs_wr < 256) begin
            obs_mem[obs_wr] <= {wr_addr, wr_data};
            obs_wr          <= obs_wr + 1;
        end
    end

    function automatic logic [3:0] next_a(input logic [3:0] a);
`ifdef SPI_REG_AUTOINC_EN
        return a + 4'd1;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_MOSI = tx[i];
            tick(HALF);
            rx[i]   = SPI_MISO;
            SPI_Clk = 1'b1;
            tick(HALF);
            SPI_Clk = 1'b0;
        end
    endtask

    task automatic chk_strobes();
        chk("strobe_count", obs_wr - obs_rd, exp_wr_q.size());
        while (obs_rd < obs_wr && exp_wr_q.size() > 0) begin
            chk("strobe_addr_data", obs_mem[obs_rd], exp_wr_q.pop_front());
            obs_rd++;
        end
        exp_wr_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            chk($sformatf("rd_data[%0d]", i), rd_data, model[i]);
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] rx;
        logic [7:0] d;
        logic [3:0] a;
        logic       rd;
        rd = cmd[7];
        a  = cmd[3:0];
        SPI_CS = 1'b0;
        tick(HALF);
        exp_miso_q.push_back(8'hA5);
        xfer(cmd, 8, rx);
        chk("miso_cmd", rx, exp_miso_q.pop_front());
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? b0 : b1;
            if (rd) begin
                exp_miso_q.push_back(model[a]);
            end else begin
                exp_miso_q.push_back(8'hA5);
                exp_wr_q.push_back({a, d});
                model[a] = d;
            end
            xfer(d, 8, rx);
            chk("miso_data", rx, exp_miso_q.pop_front());
            a = next_a(a);
        end
        tick(HALF);
        SPI_CS = 1'b1;
        tick(HALF);
        chk_strobes();
        chk("miso_idle", SPI_MISO, 0);
        chk_regs();
    endtask

    initial begin
        logic [7:0] rx;
        resetn   = 1'b0;
        SPI_CS   = 1'b1;
        SPI_Clk  = 1'b0;
        SPI_MOSI = 1'b0;
        rd_addr  = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        tick(4);
        chk("rst_miso", SPI_MISO, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk_regs();
        resetn = 1'b1;
        tick(8);

        // Fixed-address (or auto-increment) burst on a clean register file.
        txn(8'h02, 2, 8'h11, 8'h22);
        // Single write, then read it back after the status byte.
        txn(8'h03, 1, 8'hC1, 8'h00);
        txn(8'h83, 1, 8'h00, 8'h00);
        // Burst starting at 15 exercises address wrap when incrementing.
        txn(8'h0F, 2, 8'hAA, 8'hBB);
        txn(8'h82, 2, 8'h00, 8'h00);
        txn(8'h8F, 2, 8'h00, 8'h00);

        // Partial data byte aborted by CS rise: no write, next transfer normal.
        SPI_CS = 1'b0;
        tick(HALF);
        xfer(8'h05, 8, rx);
        chk("partial_miso_cmd", rx, 8'hA5);
        xfer(8'hFF, 4, rx);
        tick(HALF);
        SPI_CS = 1'b1;
        tick(HALF);
        chk_strobes();
        chk_regs();
        txn(8'h05, 1, 8'h5A, 8'h00);

        // Reset in the middle of a data byte with CS still low.
        SPI_CS = 1'b0;
        tick(HALF);
        xfer(8'h01, 8, rx);
        chk("rstmid_miso_cmd", rx, 8'hA5);
        xfer(8'h77, 4, rx);
        resetn = 1'b0;
        tick(3);
        chk("rstmid_miso", SPI_MISO, 0);
        chk("rstmid_strobe", wr_strobe, 0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        chk_regs();
        resetn = 1'b1;
        tick(2 * HALF);
        chk("rstmid_miso_after", SPI_MISO, 0);
        SPI_CS = 1'b1;
        tick(HALF);
        chk_strobes();
        txn(8'h07, 1, 8'h3C, 8'h00);
        txn(8'h87, 1, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameter STATUS_BYTE, default 8'hA5, byte shifted on SPI_MISO during the command byte.
REQ-002 SHALL have parameter RESET_VAL, default 8'h00, reset value of every register.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port SPI_CS  input  1  chip select, active-low.
REQ-006 SHALL have port SPI_Clk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 SHALL have port SPI_MOSI  input  1  serial data in, MSB first.
REQ-008 SHALL have port SPI_MISO  output  1  serial data out, MSB first.
REQ-009 SHALL have port rd_addr  input  4  host-side register read address.
REQ-010 SHALL have port rd_data  output  8  combinational read of register[rd_addr].
REQ-011 SHALL have port wr_strobe  output  1  one-clk pulse per SPI register write.
REQ-012 SHALL have port wr_addr  output  4  address written; valid with wr_strobe.
REQ-013 SHALL have port wr_data  output  8  data written; valid with wr_strobe.

Function
REQ-014 SHALL pass SPI_CS, SPI_Clk and SPI_MOSI through 2-flop synchronizers to clk, then detect edges; the SPI_Clk half-period is at least 4 clk.
REQ-015 SHALL sample MOSI on each detected SPI_Clk rising edge into an 8-bit shift register, with a 3-bit bit counter wrapping 7->0.
REQ-016 SHALL implement states IDLE, CMD, DATA: IDLE->CMD on CS fall; CMD->DATA after 8th rising edge; DATA stays in DATA per byte; any state->IDLE on CS rise.
REQ-017 SHALL decode the command byte: bit7=1 read, bit7=0 write; bits3:0 start address; bits6:4 ignored.
REQ-018 SHALL, on the detected CS fall, load STATUS_BYTE into the TX shifter and drive bit7 on SPI_MISO before the first rising edge; the master holds CS low at least 4 clk before the first edge.
REQ-019 SHALL shift the TX shifter on detected falling edges only when the bit counter is nonzero; SPI_MISO equals TX shifter bit7.
REQ-020 SHALL, on completion of each byte in a read transaction, load register[addr] into the TX shifter (snapshot at load time).
REQ-021 SHALL, in a write transaction, update register[addr] on completion of each data byte, with wr_strobe high for exactly that one clk; the register value is visible on rd_data the next clk.
REQ-022 SHALL, after each data byte, advance addr per REQ-030/REQ-031, wrapping 15->0.
REQ-023 SHALL, in a write transaction, return STATUS_BYTE on SPI_MISO for every data byte.
REQ-024 SHALL, on CS rise mid-byte, discard the partial byte, perform no write, clear the bit counter, and return to IDLE.
REQ-025 SHALL drive SPI_MISO=0 while in IDLE.
REQ-026 SHALL ignore SPI_Clk edges while CS is high.

Reset
REQ-027 SHALL, on resetn low at a clk edge, set state=IDLE, all registers=RESET_VAL, SPI_MISO=0, wr_strobe=0, wr_addr=0, wr_data=0, and counters and shifters to 0.
REQ-028 SHALL abort any transaction by reset with no write; the first command is taken only after a fresh CS fall.
REQ-029 SHALL reset the synchronizer flops to the idle levels CS=1, Clk=0, MOSI=0.

Configuration
REQ-030 SHALL, with SPI_REG_AUTOINC_EN defined, increment addr by one after each data byte.
REQ-031 SHALL, without SPI_REG_AUTOINC_EN, hold addr fixed, so burst bytes repeatedly write or read the same register.

Structure
REQ-032 SHALL take a state enum (IDLE, CMD, DATA), NUM_REGS=16, ADDR_W=4 and CMD_READ_BIT=7 from shared package spi_reg_pkg.
REQ-033 SHALL isolate synchronizers and edge detect in one sub-module, spi_sync_edge (outputs cs_n_s, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s).

Verification
REQ-034 SHALL cover: CS low, cmd 0x03, data 0xC1, CS high -> reg3=0xC1; one wr_strobe with wr_addr=3, wr_data=0xC1.
REQ-035 SHALL cover: AUTOINC_EN, cmd 0x0F, data 0xAA, 0xBB under one CS -> reg15=0xAA, reg0=0xBB (wrap); two strobes.
REQ-036 SHALL cover: after REQ-034, cmd 0x83 plus one dummy byte -> master receives 0xA5 then 0xC1.
REQ-037 SHALL cover: cmd 0x05, 4 data bits, CS high -> no wr_strobe, reg5=0x00; the next transaction works normally.
REQ-038 SHALL cover: resetn low mid-data-byte after regs written -> all rd_data=0x00, SPI_MISO=0, no strobe.
REQ-039 SHALL cover: AUTOINC_EN undefined, cmd 0x02, data 0x11, 0x22 -> reg2=0x22, reg3=0x00.
